fm_encoder: RTL and testbench
=============================

FM_ENCODER -- requirements
Module: fm_encoder

Interface
REQ-001 Parameter CELL_CLKS, default 16, clk cycles per bit cell; even, >= 8.
REQ-002 Parameter PULSE_CLKS, default 4, clk cycles per clock/data pulse; 1 <= PULSE_CLKS < CELL_CLKS/2.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  read gate (drive selected, read active); low aborts output.
REQ-006 bit_in  in  1  serial NRZ bit from the sector read serializer.
REQ-007 bit_valid  in  1  bit_in holds a valid bit.
REQ-008 bit_ready  out  1  encoder accepts bit_in this cycle.
REQ-009 rd_clk  out  1  read-clock pulse, one per cell.
REQ-010 rd_data  out  1  read-data pulse, one per cell whose bit is 1.
REQ-011 fm_out  out  1  rd_clk | rd_data (combined double-frequency stream).
REQ-012 cell_start  out  1  single-cycle strobe on the first cycle of each cell.
REQ-013 underrun  out  1  sticky: a cell started with no bit available.

Function
REQ-014 Transfer occurs on any cycle with bit_valid && bit_ready; bit_in is captured into a one-entry holding register (hold_bit, hold_valid).
REQ-015 States IDLE, RUN; IDLE -> RUN when enable && hold_valid; RUN -> IDLE when enable is low; any state -> IDLE on rst.
REQ-016 Load event L = (IDLE && enable && hold_valid) || (RUN && enable && cnt == CELL_CLKS-1).
REQ-017 bit_ready = !hold_valid || L (combinational).
REQ-018 On L: cell_bit <= hold_bit, cnt <= 0; hold_valid clears unless a transfer occurs the same cycle, in which case hold takes the new bit.
REQ-019 On L in RUN with hold_valid low: cell_bit <= 0, underrun <= 1, cell proceeds normally.
REQ-020 cnt is $clog2(CELL_CLKS) bits, increments each RUN cycle, wraps to 0 only via L.
REQ-021 Outputs are registered from cnt/cell_bit/state: rd_clk = RUN && cnt < PULSE_CLKS; rd_data = RUN && cell_bit && CELL_CLKS/2 <= cnt < CELL_CLKS/2 + PULSE_CLKS; cell_start = RUN && cnt == 0.
REQ-022 Latency: bit accepted in IDLE at cycle t (enable high) -> cnt==0, cell_start and rd_clk high at t+2.
REQ-023 Back-to-back cells are gapless: with bits supplied each cell, cells repeat every CELL_CLKS cycles exactly.
REQ-024 enable low in RUN: next cycle state IDLE, rd_clk/rd_data/fm_out/cell_start low; hold contents retained; a partial pulse is truncated, never extended.
REQ-025 underrun clears only on rst or while state is IDLE and enable is low.
REQ-026 In IDLE the holding register accepts one bit regardless of enable.

Reset
REQ-027 rst: state IDLE, cnt 0, cell_bit 0, hold_valid 0, underrun 0; rd_clk, rd_data, fm_out, cell_start 0; bit_ready 1 the cycle after reset releases.
REQ-028 rst asserted mid-cell overrides all events that cycle; the pending held bit is discarded.

Structure
REQ-029 disk_pkg holds the state enum and default CELL_CLKS/PULSE_CLKS constants shared with the read serializer and write decoder.
REQ-030 Single module, no sub-module; parameter legality checked with an elaboration-time assertion.

Verification
REQ-031 Reset with defaults -> all outputs 0, bit_ready 1, underrun 0.
REQ-032 enable=1, bits 1,0,1 each offered at bit_ready -> rd_clk high cnt 0-3 of every cell; rd_data high cnt 8-11 in cells 1 and 3 only; cell period 16 cycles; underrun 0.
REQ-033 Feed bit 1 then withhold bit_valid -> cell 2 has rd_clk only, no rd_data, underrun 1 from its cell_start onward until enable low in IDLE.
REQ-034 Bit offered exactly at cnt==15 with hold full -> transfer accepted that cycle, cell_bit takes old bit, new bit appears in following cell.
REQ-035 Drop enable at cnt==2 -> rd_clk low the next cycle, state IDLE; re-raise enable -> restart at cnt 0 using retained held bit.
REQ-036 Assert rst at cnt==9 of a 1-cell -> rd_data low next cycle, hold_valid 0, state IDLE.

Source files
------------

// File: rtl/disk_pkg.sv
// Shared definitions for the floppy read path: encoder state encoding and the
// default bit-cell timing used by the read serializer and the write decoder.
package disk_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fm_state_e;

   localparam int unsigned DEF_CELL_CLKS  = 16;
   localparam int unsigned DEF_PULSE_CLKS = 4;

endpackage : disk_pkg

// File: rtl/fm_encoder.sv
// FM read-side encoder: turns a serial NRZ bit stream into per-cell clock and
// data pulses. One-entry holding register in front of the cell timer, so the
// next bit can be accepted while the current cell is still being emitted.
module fm_encoder
   import disk_pkg::*;
#(
   parameter int unsigned CELL_CLKS  = DEF_CELL_CLKS,
   parameter int unsigned PULSE_CLKS = DEF_PULSE_CLKS
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic bit_in,
   input  logic bit_valid,
   output logic bit_ready,
   output logic rd_clk,
   output logic rd_data,
   output logic fm_out,
   output logic cell_start,
   output logic underrun
);

   localparam int unsigned   CW       = $clog2(CELL_CLKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(CELL_CLKS - 1);
   localparam logic [CW-1:0] CLK_END  = CW'(PULSE_CLKS);
   localparam logic [CW-1:0] DATA_LO  = CW'(CELL_CLKS / 2);
   localparam logic [CW-1:0] DATA_HI  = CW'(CELL_CLKS / 2 + PULSE_CLKS);

   // Reject timing parameters that would overlap the clock and data pulses.
   if (CELL_CLKS < 8 || (CELL_CLKS % 2) != 0 || PULSE_CLKS < 1 ||
       PULSE_CLKS >= CELL_CLKS / 2) begin : g_bad_params
      $error("fm_encoder: illegal CELL_CLKS/PULSE_CLKS combination");
   end

   fm_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cell_bit_q, cell_bit_d;
   logic          hold_bit_q, hold_bit_d;
   logic          hold_valid_q, hold_valid_d;
   logic          underrun_q, underrun_d;
   logic          rd_clk_q, rd_clk_d;
   logic          rd_data_q, rd_data_d;
   logic          fm_out_q, fm_out_d;
   logic          cell_start_q, cell_start_d;
   logic          load, xfer, run_d;

   // Next-state: load/handshake decode, holding register, cell timer and the
   // output pulses decoded from the next state so outputs come straight off flops.
   always_comb begin
      load = enable && ((state_q == ST_IDLE && hold_valid_q) ||
                        (state_q == ST_RUN  && cnt_q == CNT_LAST));
      bit_ready = !hold_valid_q || load;
      xfer      = bit_valid && bit_ready;

      state_d      = state_q;
      cnt_d        = cnt_q;
      cell_bit_d   = cell_bit_q;
      hold_bit_d   = hold_bit_q;
      hold_valid_d = hold_valid_q;
      underrun_d   = underrun_q;

      // A load empties the holder; a same-cycle transfer refills it.
      if (load) hold_valid_d = 1'b0;
      if (xfer) begin
         hold_bit_d   = bit_in;
         hold_valid_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (!enable) underrun_d = 1'b0;
            if (load) begin
               state_d    = ST_RUN;
               cnt_d      = '0;
               cell_bit_d = hold_bit_q;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (load) begin
               // Empty holder at a cell boundary: emit a zero cell and flag it.
               cnt_d      = '0;
               cell_bit_d = hold_valid_q && hold_bit_q;
               if (!hold_valid_q) underrun_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      run_d        = (state_d == ST_RUN);
      rd_clk_d     = run_d && (cnt_d < CLK_END);
      rd_data_d    = run_d && cell_bit_d && (cnt_d >= DATA_LO) && (cnt_d < DATA_HI);
      cell_start_d = run_d && (cnt_d == '0);
      fm_out_d     = rd_clk_d || rd_data_d;
   end

   // State and output registers; reset wins over every other event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         cell_bit_q   <= 1'b0;
         hold_bit_q   <= 1'b0;
         hold_valid_q <= 1'b0;
         underrun_q   <= 1'b0;
         rd_clk_q     <= 1'b0;
         rd_data_q    <= 1'b0;
         fm_out_q     <= 1'b0;
         cell_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cell_bit_q   <= cell_bit_d;
         hold_bit_q   <= hold_bit_d;
         hold_valid_q <= hold_valid_d;
         underrun_q   <= underrun_d;
         rd_clk_q     <= rd_clk_d;
         rd_data_q    <= rd_data_d;
         fm_out_q     <= fm_out_d;
         cell_start_q <= cell_start_d;
      end
   end

   assign rd_clk     = rd_clk_q;
   assign rd_data    = rd_data_q;
   assign fm_out     = fm_out_q;
   assign cell_start = cell_start_q;
   assign underrun   = underrun_q;

endmodule : fm_encoder

// File: tb/tb_fm_encoder.sv
// Bench for fm_encoder: accepted bits go into a scoreboard queue tagged with
// the edge that took them; the monitor consumes them at cell boundaries and
// checks every output against a cell-level model each cycle.
module tb_fm_encoder;

   localparam int CELL  = 16;
   localparam int PULSE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   logic bit_in = 1'b0;
   logic bit_valid = 1'b0;
   logic bit_ready, rd_clk, rd_data, fm_out, cell_start, underrun;

   fm_encoder #(.CELL_CLKS(CELL), .PULSE_CLKS(PULSE)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .bit_ready  (bit_ready),
      .rd_clk     (rd_clk),
      .rd_data    (rd_data),
      .fm_out     (fm_out),
      .cell_start (cell_start),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic b;
      int   cyc;
   } ent_t;

   ent_t q[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   logic acc_n = 1'b0, acc_b = 1'b0;
   logic en_prev = 1'b0, rst_prev = 1'b1;
   logic m_run = 1'b0, m_bit = 1'b0, m_und = 1'b0;
   int   m_k = 0;
   bit   done = 1'b0;

   task automatic chk(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, exp);
      end
   endtask

   // Scoreboard push: a bit seen handshaking before this edge was taken here.
   always @(posedge clk) begin
      cyc++;
      if (acc_n) q.push_back('{b: acc_b, cyc: cyc});
   end

   // Monitor: advance the cell model across the edge just taken, then compare.
   always @(negedge clk) begin
      logic was_run, load, elig, l_next;
      ent_t tmp;
      if (!done) begin
         was_run = m_run;
         if (rst_prev) begin
            q.delete();
            m_run = 1'b0; m_k = 0; m_bit = 1'b0; m_und = 1'b0;
         end else begin
            // A bit is usable for a cell only if it was taken on an earlier edge.
            elig = (q.size() > 0) && (q[0].cyc < cyc);
            load = en_prev && (was_run ? (m_k == CELL - 1) : elig);
            if (was_run && !en_prev) begin
               m_run = 1'b0;
            end else if (load) begin
               m_run = 1'b1;
               m_k   = 0;
               if (elig) begin
                  tmp   = q.pop_front();
                  m_bit = tmp.b;
               end else begin
                  m_bit = 1'b0;
                  m_und = 1'b1;
               end
            end else if (was_run) begin
               m_k++;
            end
            if (!was_run && !en_prev) m_und = 1'b0;
         end

         chk("rd_clk",     rd_clk,     m_run && (m_k < PULSE));
         chk("rd_data",    rd_data,    m_run && m_bit && (m_k >= CELL/2) && (m_k < CELL/2 + PULSE));
         chk("fm_out",     fm_out,     m_run && ((m_k < PULSE) || (m_bit && (m_k >= CELL/2) && (m_k < CELL/2 + PULSE))));
         chk("cell_start", cell_start, m_run && (m_k == 0));
         chk("underrun",   underrun,   m_und);
         l_next = enable && (m_run ? (m_k == CELL - 1) : (q.size() > 0));
         chk("bit_ready",  bit_ready,  (q.size() == 0) || l_next);

         acc_n    = bit_valid && bit_ready;
         acc_b    = bit_in;
         en_prev  = enable;
         rst_prev = rst;
      end
   end

   task automatic drive(input logic v, input logic b, input logic e, input logic r);
      @(posedge clk); #1;
      bit_valid = v; bit_in = b; enable = e; rst = r;
   endtask

   // Hold a bit on the input until the encoder takes it.
   task automatic offer(input logic b);
      int n;
      n = 0;
      bit_valid = 1'b1; bit_in = b;
      forever begin
         @(negedge clk);
         if (bit_ready) break;
         n++;
         if (n > 4 * CELL) begin
            n_vec++; n_err++;
            $display("FAIL offer_timeout cyc=%0d actual=no_ready required=ready", cyc);
            break;
         end
      end
      @(posedge clk); #1;
      bit_valid = 1'b0;
   endtask

   task automatic wait_cell_start();
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (cell_start) break;
         n++;
         if (n > 4 * CELL) begin
            n_vec++; n_err++;
            $display("FAIL cell_start_timeout cyc=%0d actual=0 required=1", cyc);
            break;
         end
      end
   endtask

   initial begin
      logic [2:0] pat;
      int pv, drop;
      logic e, r;

      // Reset, then release with everything idle.
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);

      // Bits 1,0,1 offered as the encoder becomes ready, then starvation.
      enable = 1'b1;
      pat = 3'b101;
      for (int i = 2; i >= 0; i--) offer(pat[i]);
      repeat (4 * CELL) drive(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);

      // Continuous supply: bit offered at every cell end with the holder full.
      repeat (10 * CELL) drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);

      // Drop enable two cycles into a cell, then resume from the held bit.
      wait_cell_start();
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3 * CELL) drive(1'b1, 1'b1, 1'b1, 1'b0);

      // Reset landing in the data window of a one-cell.
      wait_cell_start();
      repeat (8) drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (2 * CELL) drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);

      // Random traffic: varying supply rate, enable drops, rare resets.
      drop = 0;
      for (int blk = 0; blk < 16; blk++) begin
         pv = $urandom_range(2, 10);
         for (int i = 0; i < 200; i++) begin
            if (drop > 0) begin
               drop--;
               e = 1'b0;
            end else if ($urandom_range(0, 99) < 2) begin
               drop = $urandom_range(0, 20);
               e = 1'b0;
            end else begin
               e = 1'b1;
            end
            r = ($urandom_range(0, 499) == 0);
            drive(($urandom_range(0, 9) < pv), 1'($urandom_range(0, 1)), e, r);
         end
      end

      repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fm_encoder
